// File: rtl/full_subtractor_unit_pkg.sv
// Shared constants for the registered ripple-borrow subtractor.
package full_subtractor_unit_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit combinational full-subtractor cell: diff = a ^ b ^ bin, borrow-out to next bit.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  always_comb begin
    diff = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/full_subtractor_unit.sv
// Registered WIDTH-bit ripple-borrow subtractor: {bout, diff} = a - b - bin, one-cycle latency.
module full_subtractor_unit
  import full_subtractor_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             out_valid
);

  logic [WIDTH:0]   borrow;
  logic [WIDTH-1:0] diff_comb;

  logic [WIDTH-1:0] diff_d, diff_q;
  logic             bout_d, bout_q;
  logic             out_valid_d, out_valid_q;

  assign borrow[0] = bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_subtractor_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (borrow[i]),
      .diff (diff_comb[i]),
      .bout (borrow[i+1])
    );
  end

  // Idle cycles select the held value, so X on the operands never reaches the register.
  always_comb begin
    diff_d      = diff_q;
    bout_d      = bout_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      diff_d = diff_comb;
      bout_d = borrow[WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q      <= '0;
      bout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign diff      = diff_q;
  assign bout      = bout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_subtractor_unit.sv
// Self-checking bench: WIDTH=1 exhaustive, WIDTH=4 edges/hold/async reset, WIDTH=8 random sweep.
module tb_full_subtractor_unit;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       v1_in, b1_in, bin1, d1, bo1, ov1;
  logic       a1;
  logic       v4_in, bin4, bo4, ov4;
  logic [3:0] a4, b4, d4;
  logic       v8_in, bin8, bo8, ov8;
  logic [7:0] a8, b8, d8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  full_subtractor_unit #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1_in), .a(a1), .b(b1_in), .bin(bin1),
    .diff(d1), .bout(bo1), .out_valid(ov1)
  );

  full_subtractor_unit #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(v4_in), .a(a4), .b(b4), .bin(bin4),
    .diff(d4), .bout(bo4), .out_valid(ov4)
  );

  full_subtractor_unit #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8_in), .a(a8), .b(b8), .bin(bin8),
    .diff(d8), .bout(bo8), .out_valid(ov8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t t1[8];
  vec_t t4[3];

  initial begin
    logic [8:0] exp8;
    logic       exp_valid8;

    t1[0] = '{8'd0, 8'd0, 1'b0, 8'd0, 1'b0};
    t1[1] = '{8'd0, 8'd0, 1'b1, 8'd1, 1'b1};
    t1[2] = '{8'd0, 8'd1, 1'b0, 8'd1, 1'b1};
    t1[3] = '{8'd0, 8'd1, 1'b1, 8'd0, 1'b1};
    t1[4] = '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0};
    t1[5] = '{8'd1, 8'd0, 1'b1, 8'd0, 1'b0};
    t1[6] = '{8'd1, 8'd1, 1'b0, 8'd0, 1'b0};
    t1[7] = '{8'd1, 8'd1, 1'b1, 8'd1, 1'b1};

    t4[0] = '{8'h0, 8'h0, 1'b1, 8'hF, 1'b1};
    t4[1] = '{8'hF, 8'hF, 1'b1, 8'hF, 1'b1};
    t4[2] = '{8'h9, 8'h3, 1'b0, 8'h6, 1'b0};

    v1_in = 0; a1 = 0; b1_in = 0; bin1 = 0;
    v4_in = 0; a4 = 0; b4 = 0; bin4 = 0;
    v8_in = 0; a8 = 0; b8 = 0; bin8 = 0;

    // Reset state, with a valid input that must be dropped while rst is high.
    v4_in = 1; a4 = 4'h9; b4 = 4'h3;
    step();
    check("rst_w1_diff", d1, 0);
    check("rst_w1_bout", bo1, 0);
    check("rst_w1_valid", ov1, 0);
    check("rst_w4_diff", d4, 0);
    check("rst_w4_valid", ov4, 0);
    check("rst_w8_valid", ov8, 0);
    v4_in = 0;
    rst = 0;

    // WIDTH=1 exhaustive, one vector per clock.
    for (int i = 0; i < 8; i++) begin
      v1_in = 1; a1 = t1[i].a[0]; b1_in = t1[i].b[0]; bin1 = t1[i].bin;
      step();
      check($sformatf("w1_diff_%0d", i), d1, t1[i].diff[0]);
      check($sformatf("w1_bout_%0d", i), bo1, t1[i].bout);
      check($sformatf("w1_valid_%0d", i), ov1, 1);
    end
    v1_in = 0;
    step();
    check("w1_valid_drop", ov1, 0);

    // WIDTH=4 edge cases.
    for (int i = 0; i < 3; i++) begin
      v4_in = 1; a4 = t4[i].a[3:0]; b4 = t4[i].b[3:0]; bin4 = t4[i].bin;
      step();
      check($sformatf("w4_diff_%0d", i), d4, t4[i].diff[3:0]);
      check($sformatf("w4_bout_%0d", i), bo4, t4[i].bout);
      check($sformatf("w4_valid_%0d", i), ov4, 1);
    end

    // Hold: capture 1-0-0, then idle with changed and unknown operands.
    v4_in = 1; a4 = 4'h1; b4 = 4'h0; bin4 = 0;
    step();
    check("hold_diff_cap", d4, 1);
    check("hold_bout_cap", bo4, 0);
    v4_in = 0; a4 = 4'h0; b4 = 4'hF; bin4 = 1;
    step();
    check("hold_diff_1", d4, 1);
    check("hold_bout_1", bo4, 0);
    check("hold_valid_1", ov4, 0);
    a4 = 'x; b4 = 'x; bin4 = 1'bx;
    step();
    check("hold_diff_x", d4, 1);
    check("hold_bout_x", bo4, 0);
    check("hold_valid_x", ov4, 0);

    // Asynchronous reset mid-stream, between clock edges.
    v4_in = 1; a4 = 4'h0; b4 = 4'h1; bin4 = 0;
    step();
    check("pre_rst_diff", d4, 4'hF);
    check("pre_rst_valid", ov4, 1);
    #2 rst = 1;
    #1;
    check("async_rst_diff", d4, 0);
    check("async_rst_bout", bo4, 0);
    check("async_rst_valid", ov4, 0);
    a4 = 4'h5; b4 = 4'h7; bin4 = 0;
    step();
    check("rst_edge_drop_valid", ov4, 0);
    check("rst_edge_drop_diff", d4, 0);
    rst = 0;
    step();
    check("post_rst_diff", d4, 4'hE);
    check("post_rst_bout", bo4, 1);
    check("post_rst_valid", ov4, 1);
    v4_in = 0;

    // WIDTH=8 random sweep against an arithmetic reference.
    exp8 = '0;
    exp_valid8 = 0;
    for (int i = 0; i < 1000; i++) begin
      v8_in = 1'($urandom_range(0, 1));
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      bin8 = 1'($urandom_range(0, 1));
      if (v8_in) exp8 = {1'b0, a8} - {1'b0, b8} - {8'd0, bin8};
      exp_valid8 = v8_in;
      step();
      check("w8_result", {bo8, d8}, exp8);
      check("w8_valid", ov8, exp_valid8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
